midi_note_tx: RTL and testbench

- MIDI transmitter for the CyberSynth: converts note-on/note-off events into standard 3-byte MIDI channel-voice messages and serializes them as 31250-baud UART on a single output pin.
- Reverse direction of the MIDI receive → envelope path. Drives external synths and provides loopback stimulus for our own MIDI input chain.
- Optional running-status compression.

---
 rtl/midi_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 105 ++++++++++
 rtl/midi_note_tx.sv | 98 +++++++++
 tb/tb_midi_note_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared types and helpers for the MIDI transmit path.
// Status nibbles, bit-period helper and the UART frame state enum.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, one byte per start/ready handshake.
// Ports: CLK250M, RST, start, data[7:0] in; ready, near_end, midi_tx out.
// ready is also high in the last cycle of a stop bit so that the next
// byte's start bit follows with no idle gap. near_end flags the
// second-to-last stop cycle so the sequencer can release its handshake
// one cycle ahead.
module uart_tx_byte
    import midi_pkg::*;
#(
    parameter int BIT_CYCLES = 8000
) (
    input  logic       CLK250M,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       near_end,
    output logic       midi_tx
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] NEAR = CW'(BIT_CYCLES - 2);

    tx_state_t     state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg, sh_nxt;
    logic          last;
    logic          line_d;

    assign last = (cnt == LAST);

    // State register
    always_ff @(posedge CLK250M) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            midi_tx <= 1'b1;
        end else begin
            state   <= nxt;
            shreg   <= sh_nxt;
            midi_tx <= line_d;
            if (state == IDLE || nxt != state || last)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == DATA && last)
                bit_idx <= bit_idx + 3'd1;
            else if (nxt == START)
                bit_idx <= '0;
        end
    end

    // Next-state logic; the shift register moves one bit per data period
    always_comb begin
        nxt    = state;
        sh_nxt = shreg;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt    = START;
                    sh_nxt = data;
                end
            end
            START: begin
                if (last)
                    nxt = DATA;
            end
            DATA: begin
                if (last) begin
                    sh_nxt = {1'b1, shreg[7:1]};
                    if (bit_idx == 3'd7)
                        nxt = STOP;
                end
            end
            STOP: begin
                if (last) begin
                    if (start) begin
                        nxt    = START;
                        sh_nxt = data;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs; the line level is computed from the next state so the
    // registered pin changes on the same edge as the state
    always_comb begin
        ready    = (state == IDLE) || (state == STOP && last);
        near_end = (state == STOP) && (cnt == NEAR);
        line_d   = 1'b1;
        if (nxt == START)
            line_d = 1'b0;
        else if (nxt == DATA)
            line_d = sh_nxt[0];
    end

endmodule

// File: rtl/midi_note_tx.sv
// midi_note_tx: note-on/off events to 3-byte MIDI messages on a UART pin.
// Ports: CLK250M, RST, ev_valid/ev_on/ev_channel/ev_note/ev_velocity in;
// ev_ready, midi_tx, busy, tx_done out. Optional running status.
module midi_note_tx
    import midi_pkg::*;
#(
    parameter int CLK_HZ         = 250000000,
    parameter int BAUD           = 31250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       CLK250M,
    input  logic       RST,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_on,
    input  logic [3:0] ev_channel,
    input  logic [6:0] ev_note,
    input  logic [6:0] ev_velocity,
    output logic       midi_tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);

    logic [7:0] status_now, last_status;
    logic [7:0] note_q, vel_q;
    logic       last_valid;
    logic [1:0] bidx;
    logic       busy_q, done_q;
    logic       skip, accept, advance;
    logic       u_start, u_ready, u_near;
    logic [7:0] u_data;

    assign status_now = {ev_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF, ev_channel};
    assign skip    = (RUNNING_STATUS != 0) && last_valid
                     && (status_now == last_status);
    assign accept  = ev_valid && !busy_q;
    // bidx is the byte currently on the line; advance hands over the next
    assign advance = busy_q && u_ready && (bidx != 2'd2);

    always_comb begin
        u_start = accept || advance;
        if (accept)
            u_data = skip ? {1'b0, ev_note} : status_now;
        else if (bidx == 2'd0)
            u_data = note_q;
        else
            u_data = vel_q;
    end

    // Busy drops one cycle before the final stop bit ends, so a new event
    // is accepted exactly as that stop bit completes.
    always_ff @(posedge CLK250M) begin
        if (RST) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_valid  <= 1'b0;
            last_status <= '0;
            note_q      <= '0;
            vel_q       <= '0;
            bidx        <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q      <= 1'b1;
                note_q      <= {1'b0, ev_note};
                vel_q       <= {1'b0, ev_velocity};
                bidx        <= skip ? 2'd1 : 2'd0;
                last_status <= status_now;
                last_valid  <= 1'b1;
            end else if (advance) begin
                bidx <= bidx + 2'd1;
            end
            if (busy_q && bidx == 2'd2 && u_near) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign ev_ready = !busy_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

    uart_tx_byte #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_uart (
        .CLK250M  (CLK250M),
        .RST      (RST),
        .start    (u_start),
        .data     (u_data),
        .ready    (u_ready),
        .near_end (u_near),
        .midi_tx  (midi_tx)
    );

endmodule

// File: tb/tb_midi_note_tx.sv
// tb_midi_note_tx: directed bench for midi_note_tx, short bit period.
// Decodes the serial line cycle by cycle and checks bytes and handshake.
module tb_midi_note_tx;

    localparam int CLK_HZ = 16;
    localparam int BAUD   = 2;
    localparam int BC     = 8;

    logic       CLK250M = 1'b0;
    logic       RST     = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_on    = 1'b0;
    logic [3:0] ev_channel  = '0;
    logic [6:0] ev_note     = '0;
    logic [6:0] ev_velocity = '0;
    logic       use0 = 1'b0;

    logic v1, rdy1, tx1, busy1, done1;
    logic v0, rdy0, tx0, busy0, done0;
    logic s_tx, s_rdy, s_busy, s_done;

    int vectors     = 0;
    int miscompares = 0;

    always #2 CLK250M = ~CLK250M;

    assign v1 = ev_valid & ~use0;
    assign v0 = ev_valid & use0;
    assign s_tx   = use0 ? tx0 : tx1;
    assign s_rdy  = use0 ? rdy0 : rdy1;
    assign s_busy = use0 ? busy0 : busy1;
    assign s_done = use0 ? done0 : done1;

    midi_note_tx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1)
    ) dut (
        .CLK250M(CLK250M), .RST(RST), .ev_valid(v1), .ev_ready(rdy1),
        .ev_on(ev_on), .ev_channel(ev_channel), .ev_note(ev_note),
        .ev_velocity(ev_velocity), .midi_tx(tx1), .busy(busy1),
        .tx_done(done1)
    );

    midi_note_tx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(0)
    ) dut0 (
        .CLK250M(CLK250M), .RST(RST), .ev_valid(v0), .ev_ready(rdy0),
        .ev_on(ev_on), .ev_channel(ev_channel), .ev_note(ev_note),
        .ev_velocity(ev_velocity), .midi_tx(tx0), .busy(busy0),
        .tx_done(done0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic o, input logic [3:0] ch,
                         input logic [6:0] n, input logic [6:0] v);
        ev_on       = o;
        ev_channel  = ch;
        ev_note     = n;
        ev_velocity = v;
    endtask

    // acc=0: the event is already presented and accepted at the next edge.
    // hold=1: ev_valid stays high with junk data, then the next event.
    task automatic xfer(input string tag, input bit acc,
                        input logic o, input logic [3:0] ch,
                        input logic [6:0] n, input logic [6:0] v,
                        input int nb, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input bit hold, input logic no,
                        input logic [3:0] nch, input logic [6:0] nn,
                        input logic [6:0] nv);
        logic       ln [0:30*BC-1];
        logic [7:0] ex [0:2];
        logic [7:0] got;
        logic       bv, lastc;
        int         n_cyc, t, werr, ferr, hs;
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        n_cyc = nb * 10 * BC;
        werr = 0; ferr = 0; hs = 0;
        if (acc) begin
            t = 0;
            @(negedge CLK250M);
            while (!s_rdy && t < 2000) begin
                @(negedge CLK250M);
                t++;
            end
            if (!s_rdy) check({tag, ".rdy_wait"}, 32'd0, 32'd1);
            drive(o, ch, n, v);
            ev_valid = 1'b1;
        end
        @(posedge CLK250M);
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge CLK250M);
            ln[c] = s_tx;
            lastc = (c == n_cyc - 1);
            if (s_rdy !== lastc || s_done !== lastc || s_busy !== !lastc)
                hs++;
            if (hold) begin
                ev_valid = 1'b1;
                if (lastc)
                    drive(no, nch, nn, nv);
                else
                    drive(1'($urandom_range(0, 1)), 4'($urandom),
                          7'($urandom), 7'($urandom));
            end else begin
                ev_valid = 1'b0;
            end
        end
        for (int b = 0; b < nb; b++) begin
            got = '0;
            for (int j = 0; j < 10; j++) begin
                bv = ln[b*10*BC + j*BC];
                for (int k = 1; k < BC; k++)
                    if (ln[b*10*BC + j*BC + k] !== bv) werr++;
                if (j == 0 && bv !== 1'b0) ferr++;
                if (j == 9 && bv !== 1'b1) ferr++;
                if (j >= 1 && j <= 8) got[j-1] = bv;
            end
            check($sformatf("%s.byte%0d", tag, b), 32'(got), 32'(ex[b]));
        end
        check({tag, ".bitwidth"}, werr, 0);
        check({tag, ".frame"}, ferr, 0);
        check({tag, ".handshake"}, hs, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK250M);
        check("rst.midi_tx", 32'(tx1), 1);
        check("rst.ev_ready", 32'(rdy1), 1);
        check("rst.busy", 32'(busy1), 0);
        check("rst.tx_done", 32'(done1), 0);
        check("rst.midi_tx0", 32'(tx0), 1);
        RST = 1'b0;

        xfer("m1", 1, 1, 4'd0, 7'd60, 7'd100, 3,
             8'h90, 8'h3C, 8'h64, 0, 0, 0, 0, 0);
        xfer("m2", 1, 1, 4'd0, 7'd64, 7'd90, 2,
             8'h40, 8'h5A, 8'h00, 0, 0, 0, 0, 0);
        xfer("m3", 1, 0, 4'd0, 7'd64, 7'd0, 3,
             8'h80, 8'h40, 8'h00, 0, 0, 0, 0, 0);
        xfer("m4", 1, 1, 4'd3, 7'd60, 7'd100, 3,
             8'h93, 8'h3C, 8'h64, 1, 1, 4'd3, 7'd62, 7'd70);
        xfer("m5", 0, 0, 4'd0, 7'd0, 7'd0, 2,
             8'h3E, 8'h46, 8'h00, 0, 0, 0, 0, 0);

        // Reset during data bit 4 of byte1 (note 0x25, bit 4 is 0)
        @(negedge CLK250M);
        drive(1, 4'd5, 7'h25, 7'h11);
        ev_valid = 1'b1;
        @(posedge CLK250M);
        for (int c = 0; c <= 10*BC + 5*BC + 2; c++) begin
            @(negedge CLK250M);
            ev_valid = 1'b0;
        end
        check("rst_mid.pre_bit4", 32'(tx1), 0);
        RST = 1'b1;
        @(posedge CLK250M);
        #1;
        check("rst_mid.midi_tx", 32'(tx1), 1);
        check("rst_mid.ev_ready", 32'(rdy1), 1);
        check("rst_mid.busy", 32'(busy1), 0);
        @(negedge CLK250M);
        RST = 1'b0;
        xfer("m6", 1, 1, 4'd5, 7'h25, 7'h11, 3,
             8'h95, 8'h25, 8'h11, 0, 0, 0, 0, 0);

        @(negedge CLK250M);
        use0 = 1'b1;
        xfer("rs0a", 1, 1, 4'd0, 7'd60, 7'd100, 3,
             8'h90, 8'h3C, 8'h64, 0, 0, 0, 0, 0);
        xfer("rs0b", 1, 1, 4'd0, 7'd60, 7'd100, 3,
             8'h90, 8'h3C, 8'h64, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
